// File: rtl/auction_award_ctrl.sv
// Auction round controller: collects up to N bids, scans them one per cycle
// for the highest bid (lowest index on ties) and issues one award handshake.
module auction_award_ctrl #(
  parameter int unsigned bW      = 17,
  parameter int unsigned N       = 10,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          round_start,
  input  logic          bid_valid,
  output logic          bid_ready,
  input  logic [3:0]    bid_id,
  input  logic [bW-1:0] bid_value,
  output logic          bid_err,
  output logic          award_valid,
  input  logic          award_ready,
  output logic [3:0]    award_id,
  output logic [bW-1:0] award_value,
  output logic          award_none,
  output logic          busy
);

  localparam int unsigned IW = 4;
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_SCAN, S_AWARD} state_t;

  state_t          r_state;
  logic [bW-1:0]   r_bids [N];
  logic [N-1:0]    r_mask;
  logic [TW-1:0]   r_timer;
  logic [IW-1:0]   r_scan_idx;
  logic            r_best_valid;
  logic [IW-1:0]   r_best_id;
  logic [bW-1:0]   r_best_value;
  logic            r_bid_ready;
  logic            r_bid_err;
  logic            r_award_valid;
  logic [IW-1:0]   r_award_id;
  logic [bW-1:0]   r_award_value;
  logic            r_award_none;
  logic            r_busy;

  logic [N-1:0]    w_id_onehot;
  logic            w_in_range;
  logic            w_dup;
  logic            w_accept;
  logic            w_reject;
  logic            w_mask_full;
  logic            w_timeout;
  logic [bW-1:0]   w_cur_val;
  logic            w_cur_hit;
  logic            w_take;
  logic            w_final_valid;
  logic [IW-1:0]   w_final_id;
  logic [bW-1:0]   w_final_value;

  assign w_id_onehot = N'(1) << bid_id;
  assign w_in_range  = ({1'b0, bid_id} < 5'(N));
  assign w_dup       = |(r_mask & w_id_onehot);
  assign w_accept    = r_bid_ready & bid_valid & w_in_range & ~w_dup;
  assign w_reject    = r_bid_ready & bid_valid & ~w_accept;
  assign w_mask_full = &(r_mask | (w_accept ? w_id_onehot : '0));
  assign w_timeout   = (r_timer == TW'(TIMEOUT - 1));

  // Select the entry under the scan pointer
  always_comb begin
    w_cur_val = '0;
    w_cur_hit = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (r_scan_idx == IW'(i)) begin
        w_cur_val = r_bids[i];
        w_cur_hit = r_mask[i];
      end
    end
  end

  // Strict greater-than keeps the earliest index on equal bids
  assign w_take        = w_cur_hit & (~r_best_valid | (w_cur_val > r_best_value));
  assign w_final_valid = r_best_valid | w_take;
  assign w_final_id    = w_take ? r_scan_idx : r_best_id;
  assign w_final_value = w_take ? w_cur_val  : r_best_value;

  // Bid storage; validity lives in r_mask, so no reset is needed here
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < N; i++) begin
      if (w_accept && w_id_onehot[i]) r_bids[i] <= bid_value;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_mask        <= '0;
      r_timer       <= '0;
      r_scan_idx    <= '0;
      r_best_valid  <= 1'b0;
      r_best_id     <= '0;
      r_best_value  <= '0;
      r_bid_ready   <= 1'b0;
      r_bid_err     <= 1'b0;
      r_award_valid <= 1'b0;
      r_award_id    <= '0;
      r_award_value <= '0;
      r_award_none  <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_bid_err <= w_reject;
      case (r_state)
        S_IDLE: begin
          if (round_start) begin
            r_state     <= S_COLLECT;
            r_mask      <= '0;
            r_timer     <= '0;
            r_bid_ready <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        S_COLLECT: begin
          r_timer <= r_timer + TW'(1);
          if (w_accept) r_mask <= r_mask | w_id_onehot;
          if (w_mask_full || w_timeout) begin
            r_state      <= S_SCAN;
            r_bid_ready  <= 1'b0;
            r_scan_idx   <= '0;
            r_best_valid <= 1'b0;
            r_best_id    <= '0;
            r_best_value <= '0;
          end
        end
        S_SCAN: begin
          r_best_valid <= w_final_valid;
          r_best_id    <= w_final_id;
          r_best_value <= w_final_value;
          if (r_scan_idx == IW'(N - 1)) begin
            r_state       <= S_AWARD;
            r_award_valid <= 1'b1;
            r_award_none  <= ~w_final_valid;
            r_award_id    <= w_final_valid ? w_final_id : '0;
            r_award_value <= w_final_valid ? w_final_value : '0;
          end else begin
            r_scan_idx <= r_scan_idx + IW'(1);
          end
        end
        S_AWARD: begin
          if (award_ready) begin
            r_state       <= S_IDLE;
            r_award_valid <= 1'b0;
            r_award_id    <= '0;
            r_award_value <= '0;
            r_award_none  <= 1'b0;
            r_busy        <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bid_ready   = r_bid_ready;
  assign bid_err     = r_bid_err;
  assign award_valid = r_award_valid;
  assign award_id    = r_award_id;
  assign award_value = r_award_value;
  assign award_none  = r_award_none;
  assign busy        = r_busy;

endmodule

// File: tb/tb_auction_award_ctrl.sv
// Self-checking bench for auction_award_ctrl: directed rounds plus random
// rounds, checked against a per-round reference model.
module tb_auction_award_ctrl;

  localparam int unsigned BW = 17;
  localparam int unsigned N  = 10;
  localparam int unsigned TO = 12;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          round_start = 1'b0;
  logic          bid_valid = 1'b0;
  logic          bid_ready;
  logic [3:0]    bid_id = '0;
  logic [BW-1:0] bid_value = '0;
  logic          bid_err;
  logic          award_valid;
  logic          award_ready = 1'b0;
  logic [3:0]    award_id;
  logic [BW-1:0] award_value;
  logic          award_none;
  logic          busy;

  auction_award_ctrl #(.bW(BW), .N(N), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .round_start(round_start),
    .bid_valid(bid_valid), .bid_ready(bid_ready), .bid_id(bid_id),
    .bid_value(bid_value), .bid_err(bid_err), .award_valid(award_valid),
    .award_ready(award_ready), .award_id(award_id), .award_value(award_value),
    .award_none(award_none), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Per-round stimulus schedule, one slot per COLLECT cycle
  logic          s_v   [TO];
  logic [3:0]    s_id  [TO];
  logic [BW-1:0] s_val [TO];

  // Model results
  int            m_len;
  logic          m_err [TO];
  logic [3:0]    m_id;
  logic [BW-1:0] m_val;
  logic          m_none;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_sched();
    for (int k = 0; k < TO; k++) begin
      s_v[k] = 1'b0; s_id[k] = '0; s_val[k] = '0;
    end
  endtask

  // Reference: first bid per bidder counts; round closes when every bidder
  // has bid or after TO cycles; winner is the lowest id holding the max bid.
  task automatic model();
    bit [N-1:0]    seen;
    logic [BW-1:0] vals [N];
    logic [BW-1:0] mx;
    seen  = '0;
    m_len = TO;
    for (int k = 0; k < TO; k++) m_err[k] = 1'b0;
    for (int k = 0; k < TO; k++) begin
      if (s_v[k]) begin
        if (int'(s_id[k]) < int'(N) && !seen[s_id[k]]) begin
          seen[s_id[k]] = 1'b1;
          vals[s_id[k]] = s_val[k];
        end else begin
          m_err[k] = 1'b1;
        end
      end
      if (&seen) begin
        m_len = k + 1;
        break;
      end
    end
    m_none = (seen == '0);
    m_id = '0; m_val = '0;
    if (!m_none) begin
      mx = '0;
      for (int i = 0; i < int'(N); i++) if (seen[i] && vals[i] > mx) mx = vals[i];
      for (int i = int'(N) - 1; i >= 0; i--)
        if (seen[i] && vals[i] == mx) m_id = 4'(i);
      m_val = mx;
    end
  endtask

  task automatic run_round(input string name, input int stall);
    int cnt;
    model();
    round_start = 1'b1;
    tick();
    round_start = 1'b0;
    check({name, ".ready_open"}, 32'(bid_ready), 1);
    check({name, ".busy_open"}, 32'(busy), 1);
    for (int k = 0; k < m_len; k++) begin
      bid_valid = s_v[k]; bid_id = s_id[k]; bid_value = s_val[k];
      if (k > 0) check({name, ".bid_err"}, 32'(bid_err), 32'(m_err[k-1]));
      tick();
    end
    bid_valid = 1'b0;
    check({name, ".bid_err_last"}, 32'(bid_err), 32'(m_err[m_len-1]));
    check({name, ".ready_closed"}, 32'(bid_ready), 0);
    check({name, ".busy_scan"}, 32'(busy), 1);
    cnt = 0;
    while (!award_valid && cnt < 4 * int'(N)) begin
      tick();
      cnt++;
    end
    check({name, ".scan_latency"}, 32'(cnt), 32'(N));
    check({name, ".award_id"}, 32'(award_id), 32'(m_id));
    check({name, ".award_value"}, 32'(award_value), 32'(m_val));
    check({name, ".award_none"}, 32'(award_none), 32'(m_none));
    for (int c = 0; c < stall; c++) begin
      round_start = 1'($urandom_range(0, 1));
      award_ready = 1'b0;
      tick();
      check({name, ".stall_valid"}, 32'(award_valid), 1);
      check({name, ".stall_id"}, 32'(award_id), 32'(m_id));
      check({name, ".stall_value"}, 32'(award_value), 32'(m_val));
      check({name, ".stall_ready"}, 32'(bid_ready), 0);
    end
    round_start = 1'b0;
    award_ready = 1'b1;
    tick();
    award_ready = 1'b0;
    check({name, ".done_valid"}, 32'(award_valid), 0);
    check({name, ".done_outs"}, 32'({award_id, award_value, award_none}), 0);
    check({name, ".done_busy"}, 32'(busy), 0);
    tick();
    check({name, ".idle_ready"}, 32'(bid_ready), 0);
  endtask

  initial begin
    int perm [N];
    int tmp, j;
    tick();
    tick();
    check("reset.outs", 32'({bid_ready, bid_err, award_valid, award_id, award_value, award_none, busy}), 0);
    reset = 1'b0;
    tick();

    // Full round, winner id1 with 9 (tie with id3 goes to lower id)
    clear_sched();
    begin
      int vals10 [N] = '{5, 9, 3, 9, 1, 0, 7, 2, 8, 4};
      for (int k = 0; k < int'(N); k++) begin
        s_v[k] = 1'b1; s_id[k] = 4'(k); s_val[k] = BW'(vals10[k]);
      end
    end
    run_round("full", 15);
    check("full.expect_id", 32'(m_id), 1);

    // Partial round closed by timeout
    clear_sched();
    s_v[0] = 1'b1; s_id[0] = 4'd7; s_val[0] = BW'(100);
    s_v[1] = 1'b1; s_id[1] = 4'd2; s_val[1] = BW'(50);
    run_round("partial", 2);

    // Duplicate and out-of-range bids
    clear_sched();
    s_v[0] = 1'b1; s_id[0] = 4'd3;  s_val[0] = BW'(20);
    s_v[1] = 1'b1; s_id[1] = 4'd3;  s_val[1] = BW'(99);
    s_v[2] = 1'b1; s_id[2] = 4'd12; s_val[2] = BW'(500);
    s_v[3] = 1'b1; s_id[3] = 4'd0;  s_val[3] = BW'(5);
    run_round("errors", 1);

    // Empty round
    clear_sched();
    run_round("empty", 0);

    // Reset mid-collect discards stored bids
    round_start = 1'b1;
    tick();
    round_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bid_valid = 1'b1; bid_id = 4'(k); bid_value = BW'(50);
      tick();
    end
    bid_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midreset.outs", 32'({bid_ready, bid_err, award_valid, award_none, busy}), 0);
    tick();
    clear_sched();
    s_v[0] = 1'b1; s_id[0] = 4'd9; s_val[0] = BW'(1);
    run_round("after_reset", 0);

    // All-zero bids are real bids
    clear_sched();
    for (int k = 0; k < int'(N); k++) begin
      s_v[k] = 1'b1; s_id[k] = 4'(k); s_val[k] = '0;
    end
    run_round("zeros", 0);

    // Random rounds
    for (int r = 0; r < 24; r++) begin
      clear_sched();
      if (r % 3 == 0) begin
        for (int i = 0; i < int'(N); i++) perm[i] = i;
        for (int i = int'(N) - 1; i > 0; i--) begin
          j = int'($urandom_range(0, i));
          tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
        end
        for (int k = 0; k < int'(N); k++) begin
          s_v[k] = 1'b1; s_id[k] = 4'(perm[k]); s_val[k] = BW'($urandom);
        end
      end else begin
        for (int k = 0; k < int'(TO); k++) begin
          s_v[k]   = ($urandom_range(0, 3) != 0);
          s_id[k]  = 4'($urandom_range(0, 11));
          s_val[k] = BW'($urandom_range(0, 7));
        end
      end
      run_round("random", int'($urandom_range(0, 4)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
